nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle WIDTH-bit add/subtract unit that time-multiplexes one 4-bit ripple-carry slice. It processes one nibble per clock, LSB first, and holds the inter-slice carry in a flop. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency for area in datapaths too wide for a single-cycle ripple chain.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of 4 and ≥4; NSLICE = WIDTH/4.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand word offered.
- in_ready  out  1  block can accept operands (IDLE only).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: A+B+cin; 1: A−B−cin.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result; 0 whenever out_valid=0.
- cout  out  1  carry out of MSB (sub: 1 = no borrow); 0 when out_valid=0.
- ovf  out  1  two's-complement overflow; 0 when out_valid=0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid: latch a into A-shift-reg, latch (sub ? ~b : b) into B-shift-reg.
  - Carry flop ← cin XOR sub. Capture a[MSB] and effective b[MSB].
  - slice counter ← 0; go to RUN.
- RUN: each cycle, the slice adds A[3:0] + B[3:0] + carry.
  - The 4-bit result shifts into the top of the result register.
  - A and B shift right by 4; carry flop ← slice carry-out; counter increments.
  - When counter = NSLICE−1, go to DONE on that edge.
- DONE: out_valid=1. sum, cout and ovf are held stable until out_ready=1, then go to IDLE.
- Width rules:
  - sub=1, cin=0 gives A−B. sub=1, cin=1 gives A−B−1.
  - Result wraps modulo 2^WIDTH.
- ovf = (a_msb == b_eff_msb) && (sum[WIDTH-1] != a_msb).
- in_valid is ignored outside IDLE (in_ready=0). No operand is lost or double-accepted.
- out_ready is ignored outside DONE.

## Timing
- Reset (async assert, any state): FSM→IDLE. All registers→0. Outputs in_ready=1, out_valid=0, sum=0, cout=0, ovf=0. Any in-flight operation is discarded with no result.
- Reset release: first accept is possible on the first rising edge with rst_n=1.
- Accept at edge k. Slice i is computed at edge k+1+i. out_valid rises after edge k+NSLICE, so latency is NSLICE cycles.
- Result handshake at earliest edge k+NSLICE+1. in_ready rises in the following cycle. Minimum initiation interval is NSLICE+2 cycles.
- NSLICE=1: RUN lasts exactly one cycle.
- Simultaneous out handshake and in_valid: the new operand is not accepted on that edge. It is accepted on the next edge, from IDLE.

## Structure
- Shared package: FSM state typedef (IDLE/RUN/DONE) and the SLICE_W=4 constant.
- One sub-module, add4_slice:
  - Combinational 4-bit ripple-carry adder built from half/full-adder cells.
  - Ports: a[3:0], b[3:0], cin, s[3:0], cout.
  - Instantiated once.
- Top level holds the FSM, counter (clog2(NSLICE) bits, min 1), shift registers, carry flop and MSB capture flops.

## Test plan
Each scenario uses WIDTH=16.
- Basic add: a=0x1234, b=0x0FFF, cin=0, sub=0 → sum=0x2233, cout=0, ovf=0. out_valid exactly 4 cycles after the accept edge.
- Full carry ripple: a=0xFFFF, b=0x0001 → sum=0x0000, cout=1, ovf=0. The carry crosses all four slices.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, cout=0, ovf=0. Then sub=1, cin=1 on a=0x0005, b=0x0003 → sum=0x0001, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1, cout=0. Also a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 asserted.
  - out_valid and sum stay stable; in_ready=0; no second accept.
  - After out_ready=1, the pending operand is accepted one cycle later and gives the correct result.
- Reset mid-RUN: assert rst_n=0 after 2 slices.
  - All outputs read 0 and in_ready=1 immediately, before any clock edge.
  - The next operation (0x00FF+0x0001) gives 0x0100.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
// Holds the FSM state encoding, the slice width and a counter-width helper.
package nibble_serial_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The slice counter still needs one bit when there is only a single slice.
    function automatic int cnt_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand and result handshake bundle for the nibble-serial adder.
// The producer/consumer side uses master; the adder itself uses slave.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/nibble_serial_adder_add4_slice.sv
// Combinational 4-bit ripple-carry adder slice.
// It is built from one half-adder-style sum stage per bit plus the carry chain.
module add4_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W:0] c;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;

    assign c[0] = cin;

    // Each bit is a full adder made of two half adders: propagate/generate, then the carry merge.
    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign p[i]   = a[i] ^ b[i];
        assign g[i]   = a[i] & b[i];
        assign s[i]   = p[i] ^ c[i];
        assign c[i+1] = g[i] | (p[i] & c[i]);
    end

    assign cout = c[SLICE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract unit that reuses one 4-bit slice, one nibble per clock, LSB first.
// Valid/ready handshakes on the operand and result sides; latency is WIDTH/4 cycles.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = cnt_width(NSLICE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;

    logic [WIDTH-1:0]   b_eff;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_cout;
    logic [WIDTH-1:0]   res_shift;

    add4_slice u_slice (
        .a    (a_sh_q[SLICE_W-1:0]),
        .b    (b_sh_q[SLICE_W-1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    assign b_eff = bus.sub ? ~bus.b : bus.b;

    // New nibbles enter at the top so the result is aligned after the last slice.
    if (NSLICE == 1) begin : g_one_slice
        assign res_shift = slice_s;
    end else begin : g_multi_slice
        assign res_shift = {slice_s, res_q[WIDTH-1:SLICE_W]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = b_eff;
                    carry_d = bus.cin ^ bus.sub;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = b_eff[WIDTH-1];
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = res_shift;
                a_sh_d  = a_sh_q >> SLICE_W;
                b_sh_d  = b_sh_q >> SLICE_W;
                carry_d = slice_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    // After the final slice the carry flop holds the carry out of the MSB.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = bus.out_valid ? res_q : '0;
    assign bus.cout      = bus.out_valid & carry_q;
    assign bus.ovf       = bus.out_valid & (a_msb_q == b_msb_q) & (res_q[WIDTH-1] != a_msb_q);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed, table-driven bench for nibble_serial_adder at WIDTH=16.
// Also covers backpressure with a waiting operand and asynchronous reset in RUN and DONE.
module tb_nibble_serial_adder;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;
    localparam int BOUND  = 20;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;
    vec_t vecs[10];

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offers an operand, waits (bounded) for in_ready, and returns just after the accept edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
        int waited;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        waited = 0;
        while (!bus.in_ready && waited < BOUND) begin
            tick();
            waited++;
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < BOUND) begin
            tick();
            lat++;
        end
    endtask

    task automatic runVector(input vec_t v, input string tag);
        int lat;
        applyStimulus(v.a, v.b, v.cin, v.sub);
        checkOutput({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        waitResult(lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(NSLICE));
        checkOutput({tag, "_sum"}, 32'(bus.sum), 32'(v.sum));
        checkOutput({tag, "_cout"}, 32'(bus.cout), 32'(v.cout));
        checkOutput({tag, "_ovf"}, 32'(bus.ovf), 32'(v.ovf));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_post_sum"}, 32'(bus.sum), 32'd0);
        checkOutput({tag, "_post_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_sum"}, 32'(bus.sum), 32'd0);
        checkOutput({tag, "_cout"}, 32'(bus.cout), 32'd0);
        checkOutput({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
    endtask

    initial begin
        int lat;
        testsRun    = 0;
        testsFailed = 0;

        //             a          b          cin   sub   sum        cout  ovf
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0};
        vecs[9] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;

        #12;
        checkResetOutputs("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: a second operand waits with in_valid high while the result is held.
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
        bus.a        = 16'h0F0F;
        bus.b        = 16'h0101;
        bus.in_valid = 1'b1;
        waitResult(lat);
        checkOutput("bp_latency", 32'(lat), 32'(NSLICE));
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("bp_hold%0d_valid", i), 32'(bus.out_valid), 32'd1);
            checkOutput($sformatf("bp_hold%0d_sum", i), 32'(bus.sum), 32'h3333);
            checkOutput($sformatf("bp_hold%0d_ready", i), 32'(bus.in_ready), 32'd0);
            tick();
        end
        checkOutput("bp_hold3_sum", 32'(bus.sum), 32'h3333);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput("bp_after_hs_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("bp_after_hs_valid", 32'(bus.out_valid), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        checkOutput("bp_second_accepted", 32'(bus.in_ready), 32'd0);
        waitResult(lat);
        checkOutput("bp_second_latency", 32'(lat), 32'(NSLICE));
        checkOutput("bp_second_sum", 32'(bus.sum), 32'h1010);
        checkOutput("bp_second_cout", 32'(bus.cout), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput("bp_second_done", 32'(bus.in_ready), 32'd1);

        // Reset after two slices of an operation that would otherwise carry out.
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_run");
        #2;
        rst_n = 1'b1;
        runVector(vecs[6], "after_rst_run");

        // Reset while a result is being held must drop it immediately.
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        waitResult(lat);
        checkOutput("rst_done_pre_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("rst_done_pre_ovf", 32'(bus.ovf), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_done");
        #2;
        rst_n = 1'b1;
        runVector(vecs[0], "after_rst_done");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
